fp_divider: RTL and testbench

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_divider_if.sv | 13 +
 rtl/fp_div_core.sv | 57 +++++
 rtl/fp_divider.sv | 114 +++++++++++
 tb/tb_fp_divider.sv | 115 +++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field widths, constants, FSM encoding and the result packer
// used by the multi-cycle FP32 divider.
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int Q_W     = 26;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, DONE} state_e;

  // Saturates out-of-range exponents to signed infinity / signed zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [FRAC_W-1:0] f);
    if (int'(e) >= EXP_MAX)  return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (int'(e) <= 0)   return {s, 31'd0};
    else                     return {s, e[EXP_W-1:0], f};
  endfunction
endpackage

// File: rtl/fp_divider_if.sv
// Request/response bundle between a requester and the FP32 divider.
interface fp_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        div_by_zero;

  modport master (output start, a, b, input busy, done, out, div_by_zero);
  modport slave  (input start, a, b, output busy, done, out, div_by_zero);
endinterface

// File: rtl/fp_div_core.sv
// Restoring shift-subtract mantissa divider: 26 quotient bits, one per cycle,
// plus a left-shift hook used by the normaliser on the finished quotient.
module fp_div_core
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shl,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic [Q_W-1:0]    q,
  output logic              last
);
  logic [Q_W-1:0]    rem_d, rem_q, q_d, q_q, diff;
  logic [MANT_W-1:0] div_d, div_q;
  logic [4:0]        cnt_d, cnt_q;
  logic              ge;

  always_comb begin
    ge    = rem_q >= {2'b00, div_q};
    diff  = rem_q - {2'b00, div_q};
    rem_d = rem_q;
    div_d = div_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = {2'b00, ma};
      div_d = mb;
      q_d   = '0;
      cnt_d = 5'(Q_W);
    end else if (cnt_q != 5'd0) begin
      rem_d = (ge ? diff : rem_q) << 1;
      q_d   = {q_q[Q_W-2:0], ge};
      cnt_d = cnt_q - 5'd1;
    end else if (shl) begin
      q_d   = {q_q[Q_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = q_q;
  assign last = (cnt_q == 5'd1);
endmodule

// File: rtl/fp_divider.sv
// FP32 divider: operand unpack and special-case screening, FSM control,
// quotient normalisation and truncating pack around fp_div_core.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fp_divider_if.slave io
);
  state_e             state_q;
  logic [31:0]        a_q, b_q, res_q, out_q;
  logic               sign_q, busy_q, done_q, dz_q, res_dz_q;
  logic signed [9:0]  exp_q, exp_un;
  logic [EXP_W-1:0]   fa, fb, ea, eb;
  logic [MANT_W-1:0]  ma, mb;
  logic [Q_W-1:0]     q;
  logic               sgn, a_zero, b_zero, nan_in, core_load, core_last, norm_shift;

  // Zero exponent field unpacks as exponent 1 with no hidden bit.
  always_comb begin
    fa        = a_q[30:23];
    fb        = b_q[30:23];
    ea        = (fa == '0) ? 8'd1 : fa;
    eb        = (fb == '0) ? 8'd1 : fb;
    ma        = {fa != '0, a_q[FRAC_W-1:0]};
    mb        = {fb != '0, b_q[FRAC_W-1:0]};
    exp_un    = 10'(int'(ea) - int'(eb) + BIAS);
    sgn       = a_q[31] ^ b_q[31];
    a_zero    = (a_q[30:0] == '0);
    b_zero    = (b_q[30:0] == '0);
    nan_in    = (fa == 8'hFF) || (fb == 8'hFF);
    core_load = (state_q == UNPACK) && !(a_zero || b_zero || nan_in);
    norm_shift = (state_q == NORM) && !q[25] && !q[24] && (int'(exp_q) > 1);
  end

  fp_div_core u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (core_load),
    .shl  (norm_shift),
    .ma   (ma),
    .mb   (mb),
    .q    (q),
    .last (core_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      out_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_dz_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (io.start) begin
          a_q     <= io.a;
          b_q     <= io.b;
          busy_q  <= 1'b1;
          state_q <= UNPACK;
        end
        UNPACK: begin
          sign_q   <= sgn;
          exp_q    <= exp_un;
          res_dz_q <= 1'b0;
          state_q  <= DONE;
          if (b_zero) begin
            res_q    <= {sgn, 8'hFF, 23'd0};
            res_dz_q <= 1'b1;
          end else if (a_zero) begin
            res_q    <= {sgn, 31'd0};
          end else if (nan_in) begin
            res_q    <= QNAN;
          end else begin
            state_q  <= DIVIDE;
          end
        end
        DIVIDE: if (core_last) state_q <= NORM;
        NORM: begin
          if (q[25]) begin
            res_q   <= fp_pack(sign_q, exp_q, q[24:2]);
            state_q <= DONE;
          end else if (norm_shift) begin
            exp_q   <= exp_q - 10'sd1;
          end else begin
            res_q   <= fp_pack(sign_q, exp_q - 10'sd1, q[23:1]);
            state_q <= DONE;
          end
        end
        // Result becomes visible only with the done pulse.
        DONE: begin
          out_q   <= res_q;
          dz_q    <= res_dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.out         = out_q;
  assign io.div_by_zero = dz_q;
endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: results, latencies, specials,
// busy interference, start-in-DONE and mid-operation reset.
module tb_fp_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fp_divider_if io();
  fp_divider dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_dz, input int exp_lat);
    int lat = 0;
    @(negedge clk);
    io.start = 1'b1; io.a = a; io.b = b;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk({tag, ".busy_hi"}, {31'd0, io.busy}, 32'd1);
    while (!io.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".out"}, io.out, exp_out);
    chk({tag, ".dz"}, {31'd0, io.div_by_zero}, {31'd0, exp_dz});
    chk({tag, ".busy_lo"}, {31'd0, io.busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'd0, io.done}, 32'd0);
    chk({tag, ".hold"}, io.out, exp_out);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (io.done) n++;
    end
  endtask

  initial begin
    int nd;
    io.start = 1'b0; io.a = '0; io.b = '0;
    #12;
    chk("rst.out", io.out, 32'h0);
    chk("rst.busy", {31'd0, io.busy}, 32'd0);
    chk("rst.done", {31'd0, io.done}, 32'd0);
    chk("rst.dz", {31'd0, io.div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("6/2",     32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);
    run_op("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 29);
    run_op("-8/2",    32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0, 29);
    run_op("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
    run_op("-1/0",    32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2);
    run_op("-0/2",    32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 2);
    run_op("inf/2",   32'h7F800000, 32'h40000000, 32'h7FC00000, 1'b0, 2);
    run_op("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 29);
    run_op("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 29);
    run_op("den",     32'h00400000, 32'h3F000000, 32'h00800000, 1'b0, 29);
    run_op("den_shl", 32'h00200000, 32'h3E800000, 32'h00800000, 1'b0, 30);

    // Second start during DIVIDE must be ignored.
    @(negedge clk); io.start = 1'b1; io.a = 32'h40C00000; io.b = 32'h40000000;
    @(posedge clk); #1; io.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); io.start = 1'b1; io.a = 32'h3F800000; io.b = 32'h40400000;
    @(posedge clk); #1; io.start = 1'b0;
    count_done(60, nd);
    chk("intf.ndone", 32'(nd), 32'd1);
    chk("intf.out", io.out, 32'h40400000);

    // Start held only across the DONE-state edge must be ignored.
    @(negedge clk); io.start = 1'b1; io.a = 32'h40C00000; io.b = 32'h00000000;
    @(posedge clk); #1; io.start = 1'b0;
    @(posedge clk);
    @(negedge clk); io.start = 1'b1; io.a = 32'h3F800000; io.b = 32'h40400000;
    @(posedge clk); #1;
    chk("dn.done", {31'd0, io.done}, 32'd1);
    @(negedge clk); io.start = 1'b0;
    @(posedge clk); #1;
    chk("dn.busy", {31'd0, io.busy}, 32'd0);
    count_done(40, nd);
    chk("dn.ndone", 32'(nd), 32'd0);
    chk("dn.out", io.out, 32'h7F800000);

    // Reset ten cycles into DIVIDE abandons the operation.
    @(negedge clk); io.start = 1'b1; io.a = 32'h40C00000; io.b = 32'h40000000;
    @(posedge clk); #1; io.start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.out", io.out, 32'h0);
    chk("mrst.busy", {31'd0, io.busy}, 32'd0);
    chk("mrst.done", {31'd0, io.done}, 32'd0);
    chk("mrst.dz", {31'd0, io.div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    count_done(40, nd);
    chk("mrst.ndone", 32'(nd), 32'd0);
    run_op("post_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
